// File: rtl/register_file_param.sv
// Purpose: parametrised decode-stage register file with two read ports, one write port, a debug read port and a post-reset scrub.
// Latency: one edge on all read ports. An optional bypass forwards same-edge write data to reads.
// Backpressure: none. Reads and writes are accepted every edge once ready is high. Writes are ignored while scrubbing.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic [ADDR_WIDTH-1:0] read_address_debug,
  input  logic                  debug_enable,
  output logic [DATA_WIDTH-1:0] data_out_debug,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);

  // Storage has no reset so that it can map onto a RAM. The scrub engine clears it instead.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] scrub_cnt;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  user_wr;

  logic [DATA_WIDTH-1:0] raw_1;
  logic [DATA_WIDTH-1:0] raw_2;
  logic [DATA_WIDTH-1:0] raw_dbg;
  logic [DATA_WIDTH-1:0] rd_1;
  logic [DATA_WIDTH-1:0] rd_2;
  logic [DATA_WIDTH-1:0] rd_dbg;

  assign raw_1   = mem[read_address_1];
  assign raw_2   = mem[read_address_2];
  assign raw_dbg = mem[read_address_debug];

  // An architectural write happens only in the run state and outside reset.
  assign user_wr = reset && ready && write_enable;

  // Applies the zero-register and bypass rules to a raw array read.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] raw,
    input logic                  wr,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    logic [DATA_WIDTH-1:0] val;
    val = raw;
    if (BYPASS && wr && (addr == wr_addr)) val = wr_data;
    if (ZERO_REG && (addr == '0)) val = '0;
    return val;
  endfunction

  // Resolves the read data for each port.
  always_comb begin
    rd_1   = resolve(read_address_1, raw_1, user_wr, write_address, write_data_in);
    rd_2   = resolve(read_address_2, raw_2, user_wr, write_address, write_data_in);
    rd_dbg = resolve(read_address_debug, raw_dbg, user_wr, write_address, write_data_in);
  end

  // Selects the single array write port. The scrub engine owns it until ready is high.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = write_address;
    mem_wd = write_data_in;
    if (!ready) begin
      mem_we = reset;
      mem_wa = scrub_cnt;
      mem_wd = '0;
    end else begin
      mem_we = user_wr && !(ZERO_REG && (write_address == '0));
    end
  end

  // Array write. No reset on this block.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Handles reset, scrub sequencing and the registered read outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out_1     <= '0;
      data_out_2     <= '0;
      data_out_debug <= '0;
      ready          <= 1'b0;
      scrub_cnt      <= '0;
    end else if (!ready) begin
      data_out_1     <= '0;
      data_out_2     <= '0;
      data_out_debug <= '0;
      scrub_cnt      <= scrub_cnt + 1'b1;
      if (scrub_cnt == LAST_ENTRY) ready <= 1'b1;
    end else begin
      data_out_1 <= rd_1;
      data_out_2 <= rd_2;
      if (debug_enable) data_out_debug <= rd_dbg;
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param. It runs two instances from the same stimulus.
// Instance 0 uses the defaults (ZERO_REG=1, BYPASS=1). Instance 1 uses ZERO_REG=0 and BYPASS=0.
// A behavioural model is checked every cycle, and directed literal checks pin that model.
module tb_register_file_param;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  read_address_1, read_address_2, write_address, read_address_debug;
  logic        write_enable, debug_enable;
  logic [31:0] write_data_in;

  logic [1:0][31:0] d1, d2, dd;
  logic [1:0]       rdy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  register_file_param u0 (
    .clock(clock), .reset(reset),
    .read_address_1(read_address_1), .read_address_2(read_address_2),
    .data_out_1(d1[0]), .data_out_2(d2[0]),
    .write_enable(write_enable), .write_address(write_address), .write_data_in(write_data_in),
    .read_address_debug(read_address_debug), .debug_enable(debug_enable),
    .data_out_debug(dd[0]), .ready(rdy[0])
  );

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clock(clock), .reset(reset),
    .read_address_1(read_address_1), .read_address_2(read_address_2),
    .data_out_1(d1[1]), .data_out_2(d2[1]),
    .write_enable(write_enable), .write_address(write_address), .write_data_in(write_data_in),
    .read_address_debug(read_address_debug), .debug_enable(debug_enable),
    .data_out_debug(dd[1]), .ready(rdy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          zr [2] = '{1'b1, 1'b0};
  bit          bp [2] = '{1'b1, 1'b0};
  logic [31:0] m  [2][32];
  logic [31:0] e1 [2], e2 [2], ed [2];
  int          rel = 0;     // edges since the last reset release
  bit          started = 0;

  function automatic logic [31:0] mread(input int c, input logic [4:0] a);
    if (zr[c] && a == 5'd0) return 32'h0;
    if (bp[c] && write_enable && write_address == a) return write_data_in;
    return m[c][a];
  endfunction

  // Model: the array is all-zero once 32 release edges have elapsed.
  // Outputs are zero until then, and normal register-file rules apply afterwards.
  always @(posedge clock) begin
    if (!reset) begin
      started = 1;
      rel = 0;
      for (int c = 0; c < 2; c++) begin e1[c] = 0; e2[c] = 0; ed[c] = 0; end
    end else if (rel < 32) begin
      rel++;
      for (int c = 0; c < 2; c++) begin e1[c] = 0; e2[c] = 0; ed[c] = 0; end
      if (rel == 32)
        for (int c = 0; c < 2; c++) for (int a = 0; a < 32; a++) m[c][a] = 32'h0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        e1[c] = mread(c, read_address_1);
        e2[c] = mread(c, read_address_2);
        if (debug_enable) ed[c] = mread(c, read_address_debug);
      end
      for (int c = 0; c < 2; c++)
        if (write_enable && !(zr[c] && write_address == 5'd0)) m[c][write_address] = write_data_in;
    end
  end

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clock) begin
    if (started) begin
      for (int c = 0; c < 2; c++) begin
        check($sformatf("model_dout1_u%0d", c), d1[c], e1[c]);
        check($sformatf("model_dout2_u%0d", c), d2[c], e2[c]);
        check($sformatf("model_dbg_u%0d", c), dd[c], ed[c]);
        check($sformatf("model_ready_u%0d", c), {31'b0, rdy[c]}, {31'b0, (rel >= 32)});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    reset = 1'b0; write_enable = 0; debug_enable = 0;
    read_address_1 = 0; read_address_2 = 0; write_address = 0; read_address_debug = 0;
    write_data_in = 0;

    // 1: reset for two edges, then a 32-edge scrub.
    step(); step();
    check("reset_ready", {31'b0, rdy[0]}, 32'h0);
    check("reset_dout1", d1[0], 32'h0);
    check("reset_dbg", dd[1], 32'h0);
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("scrub_ready_e%0d", i), {31'b0, rdy[0]}, (i == 32) ? 32'h1 : 32'h0);
      check($sformatf("scrub_ready1_e%0d", i), {31'b0, rdy[1]}, (i == 32) ? 32'h1 : 32'h0);
    end
    for (int a = 0; a < 32; a++) begin
      read_address_1 = 5'(a);
      read_address_2 = 5'(31 - a);
      step();
      check($sformatf("clear_rd1_a%0d", a), d1[1], 32'h0);
      check($sformatf("clear_rd2_a%0d", a), d2[0], 32'h0);
    end

    // 2: write address 5, then read it on port 1 and address 0 on port 2.
    write_enable = 1; write_address = 5; write_data_in = 32'hDEADBEEF;
    step();
    write_enable = 0; read_address_1 = 5; read_address_2 = 0;
    step();
    check("rd5_u0", d1[0], 32'hDEADBEEF);
    check("rd5_u1", d1[1], 32'hDEADBEEF);
    check("rd0_u0", d2[0], 32'h0);

    // 3: write and read address 7 on the same edge.
    write_enable = 1; write_address = 7; write_data_in = 32'h12345678; read_address_1 = 7;
    step();
    check("bypass_u0", d1[0], 32'h12345678);
    check("nobypass_u1", d1[1], 32'h0);
    write_enable = 0;
    step();
    check("after_wr7_u0", d1[0], 32'h12345678);
    check("after_wr7_u1", d1[1], 32'h12345678);

    // 4: write to address 0.
    write_enable = 1; write_address = 0; write_data_in = 32'hFFFFFFFF; read_address_1 = 0;
    step();
    check("zero_bypass_u0", d1[0], 32'h0);
    write_enable = 0;
    step();
    check("zero_reg_u0", d1[0], 32'h0);
    check("plain_reg0_u1", d1[1], 32'hFFFFFFFF);

    // 5: debug read, then hold while the entry is overwritten.
    write_enable = 1; write_address = 31; write_data_in = 32'hA5A5A5A5;
    step();
    write_enable = 0; read_address_debug = 31; debug_enable = 1;
    step();
    check("dbg_rd_u0", dd[0], 32'hA5A5A5A5);
    debug_enable = 0; write_enable = 1; write_address = 31; write_data_in = 32'h0;
    step();
    write_enable = 0;
    step();
    check("dbg_hold_u0", dd[0], 32'hA5A5A5A5);
    check("dbg_hold_u1", dd[1], 32'hA5A5A5A5);

    // 6: reset at scrub count 10. Writes attempted during the rescrub must be ignored.
    reset = 0;
    step();
    reset = 1; write_enable = 1; write_address = 3; write_data_in = 32'h55;
    for (int i = 0; i < 10; i++) step();
    check("midscrub_ready", {31'b0, rdy[0]}, 32'h0);
    reset = 0;
    step();
    reset = 1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("rescrub_ready_e%0d", i), {31'b0, rdy[0]}, (i == 32) ? 32'h1 : 32'h0);
    end
    write_enable = 0; read_address_1 = 3; read_address_2 = 5;
    step();
    check("scrub_wr3_u0", d1[0], 32'h0);
    check("scrub_wr3_u1", d1[1], 32'h0);
    check("scrub_cleared5", d2[1], 32'h0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the processor's 32x32 register file.
- Configurable data width and depth.
- Optional hardwired zero register.
- Optional write-to-read bypass.
- Registered read ports and a gated debug read port.
- Post-reset scrub engine that clears the array one entry per cycle, so the storage can map to RAM.
- Sits in the decode stage, between instruction decode and the ALU operand latches.

Parameters:
DATA_WIDTH, 32, width of each entry and of all data ports
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to reads of the same address; 0 = reads return the pre-write value

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising edge of clock
read_address_1  in  ADDR_WIDTH  read port 1 address
read_address_2  in  ADDR_WIDTH  read port 2 address
data_out_1  out  DATA_WIDTH  registered read data, port 1
data_out_2  out  DATA_WIDTH  registered read data, port 2
write_enable  in  1  write strobe
write_address  in  ADDR_WIDTH  write address
write_data_in  in  DATA_WIDTH  write data
read_address_debug  in  ADDR_WIDTH  debug read address
debug_enable  in  1  1 = update data_out_debug this edge
data_out_debug  out  DATA_WIDTH  registered debug read data
ready  out  1  1 = scrub complete; reads and writes are live

Behaviour:
- Reset: reset=0 at an edge sets:
  - data_out_1, data_out_2, data_out_debug <= 0
  - ready <= 0
  - scrub counter <= 0
  - array contents are untouched in that cycle.
- Scrub state (ready=0, reset=1):
  - Each edge writes 0 to entry[scrub counter], then increments the counter.
  - The edge that clears entry DEPTH-1 also sets ready <= 1.
  - ready therefore rises after exactly DEPTH edges with reset=1 (32 for defaults).
  - During scrub: write_enable is ignored; data_out_1, data_out_2 and data_out_debug hold 0.
- Reset mid-scrub: reset=0 at any edge returns the counter to 0. Scrub restarts from entry 0 and takes the full DEPTH edges again.
- Run state (ready=1), one-cycle read latency:
  - At edge N, data_out_k <= entry[read_address_k] as sampled at edge N.
  - Both read ports are independent and may use the same address.
- Write:
  - At an edge with ready=1 and write_enable=1: entry[write_address] <= write_data_in.
  - When ZERO_REG=1 and write_address=0, the write is dropped.
- Simultaneous write and read of the same address:
  - BYPASS=1: data_out_k <= write_data_in.
  - BYPASS=0: data_out_k <= old entry value.
  - The bypass is suppressed for address 0 when ZERO_REG=1, so the read returns 0.
- ZERO_REG=1: reads of address 0 on any port return 0 regardless of array contents.
- Debug port:
  - At an edge with ready=1 and debug_enable=1, data_out_debug <= entry[read_address_debug], with the same bypass and zero rules as the read ports.
  - debug_enable=0 holds data_out_debug.
  - Reset and scrub override both cases and force 0.
- Once ready=1, it stays high until the next reset=0 edge.
- Widths: no arithmetic on data; all addresses are in range by construction since DEPTH = 2**ADDR_WIDTH.

Test Plan:
1. Defaults; hold reset=0 for 2 edges, then release -> ready=0 for edges 1..31 after release, ready=1 after edge 32; reads of every address return 0x00000000.
2. Write 0xDEADBEEF to addr 5, then read addr 5 on port 1 and addr 0 on port 2 -> data_out_1=0xDEADBEEF one edge after the read address is presented; data_out_2=0.
3. Same edge: write_enable=1, write_address=7, write_data_in=0x12345678, read_address_1=7 -> BYPASS=1: data_out_1=0x12345678 after that edge; BYPASS=0: data_out_1=0, then 0x12345678 on the next edge.
4. Write 0xFFFFFFFF to addr 0, then read addr 0 -> ZERO_REG=1: 0; ZERO_REG=0: 0xFFFFFFFF.
5. Write 0xA5A5A5A5 to addr 31, read_address_debug=31 with debug_enable=1 for one edge, then debug_enable=0 while addr 31 is rewritten with 0x0 -> data_out_debug=0xA5A5A5A5 and holds.
6. Assert reset=0 at scrub count 10, release, and attempt write_enable=1 to addr 3 with data 0x55 during scrub -> ready rises exactly 32 edges after the second release; addr 3 reads 0.
